// File: rtl/anotherworld_thread_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : anotherworld_thread_scheduler
// Purpose  : Cooperative 64-thread scheduler for the Another World bytecode
//            VM. Each frame pass first commits the pending state of every
//            slot (APPLY). It then walks the slots in order (SCAN) and offers
//            each runnable thread to the CPU (DISPATCH). The thread runs until
//            it yields (RUN). One frame_done pulse ends the pass.
// Ports    : clk          - clock, rising edge
//            reset        - synchronous, active-low reset
//            frame_start  - one-cycle pulse that starts a pass (IDLE only)
//            run_valid/run_thread/run_pc/run_ready - thread offer handshake
//            yield_valid/yield_kill/yield_pc       - end of the running slice
//            vec_valid/vec_thread/vec_pc           - setVec (pending pc)
//            chan_valid/chan_first/chan_last/chan_op - updateChannel on a
//                           range (0 unfreeze, 1 freeze, 2 delete, 3 no-op)
//            frame_done   - one-cycle pulse at the end of a pass
//            busy         - high whenever the scheduler is not idle
// Revision : 1.0 - initial release
// ============================================================================
module anotherworld_thread_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  output logic        run_valid,
  output logic [5:0]  run_thread,
  output logic [15:0] run_pc,
  input  logic        run_ready,
  input  logic        yield_valid,
  input  logic        yield_kill,
  input  logic [15:0] yield_pc,
  input  logic        vec_valid,
  input  logic [5:0]  vec_thread,
  input  logic [15:0] vec_pc,
  input  logic        chan_valid,
  input  logic [5:0]  chan_first,
  input  logic [5:0]  chan_last,
  input  logic [1:0]  chan_op,
  output logic        frame_done,
  output logic        busy
);

  localparam logic [15:0] c_pc_none = 16'hFFFF;  // inactive pc / no pending change
  localparam logic [15:0] c_pc_kill = 16'hFFFE;  // pending delete
  localparam logic [5:0]  c_last    = 6'd63;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_APPLY    = 3'd1,
    S_SCAN     = 3'd2,
    S_DISPATCH = 3'd3,
    S_RUN      = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [5:0]          r_index;
  logic [5:0]          w_index_next;

  logic [63:0][15:0]   r_pc;
  logic [63:0][15:0]   r_pend_pc;
  logic [63:0]         r_paused;
  logic [63:0]         r_pend_paused;

  logic                w_runnable;

  assign w_runnable = (r_pc[r_index] != c_pc_none) && !r_paused[r_index];

  // --------------------------------------------------------------------------
  // State and slot index registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_index <= '0;
    end else begin
      r_state <= w_state_next;
      r_index <= w_index_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    run_valid    = 1'b0;
    run_thread   = '0;
    run_pc       = '0;
    frame_done   = 1'b0;
    busy         = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_state_next = S_APPLY;
          w_index_next = '0;
        end
      end
      S_APPLY: begin
        if (r_index == c_last) begin
          w_state_next = S_SCAN;
          w_index_next = '0;
        end else begin
          w_index_next = r_index + 6'd1;
        end
      end
      S_SCAN: begin
        if (w_runnable) begin
          w_state_next = S_DISPATCH;
        end else if (r_index == c_last) begin
          w_state_next = S_DONE;
        end else begin
          w_index_next = r_index + 6'd1;
        end
      end
      S_DISPATCH: begin
        run_valid  = 1'b1;
        run_thread = r_index;
        run_pc     = r_pc[r_index];
        if (run_ready) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (yield_valid) begin
          if (r_index == c_last) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_SCAN;
            w_index_next = r_index + 6'd1;
          end
        end
      end
      S_DONE: begin
        frame_done   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Per-thread state. Statement order matters: the APPLY clear of pend_pc is
  // written first so a setVec/updateChannel request to the slot being applied
  // becomes the new pending value. A channel request is written after setVec
  // so it wins on the same thread. The copy into pc/paused always samples the
  // old pending values.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc          <= {{63{c_pc_none}}, 16'h0000};
      r_pend_pc     <= {64{c_pc_none}};
      r_paused      <= '0;
      r_pend_paused <= '0;
    end else begin
      if (r_state == S_APPLY) begin
        r_paused[r_index] <= r_pend_paused[r_index];
        if (r_pend_pc[r_index] == c_pc_kill) begin
          r_pc[r_index] <= c_pc_none;
        end else if (r_pend_pc[r_index] != c_pc_none) begin
          r_pc[r_index] <= r_pend_pc[r_index];
        end
        r_pend_pc[r_index] <= c_pc_none;
      end

      if ((r_state == S_RUN) && yield_valid) begin
        r_pc[r_index] <= yield_kill ? c_pc_none : yield_pc;
      end

      if (vec_valid) begin
        r_pend_pc[vec_thread] <= vec_pc;
      end

      // An inverted range (first > last) matches no slot.
      if (chan_valid) begin
        for (int t = 0; t < 64; t++) begin
          if ((6'(t) >= chan_first) && (6'(t) <= chan_last)) begin
            case (chan_op)
              2'd0:    r_pend_paused[t] <= 1'b0;
              2'd1:    r_pend_paused[t] <= 1'b1;
              2'd2:    r_pend_pc[t]     <= c_pc_kill;
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/anotherworld_thread_scheduler.md
ANOTHERWORLD_THREAD_SCHEDULER -- requirements
Module: anotherworld_thread_scheduler

Interface
REQ-001 SHALL have ports: clk  input  1  clock, all logic on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-low reset.
REQ-003 SHALL have: frame_start  input  1  one-cycle pulse, start of one frame pass.
REQ-004 SHALL have: run_valid  output  1 / run_thread  output  6 / run_pc  output  16; offer of a thread to the CPU.
REQ-005 SHALL have: run_ready  input  1  CPU accepts offer.
REQ-006 SHALL have: yield_valid  input  1 / yield_kill  input  1 / yield_pc  input  16; running thread ends its slice.
REQ-007 SHALL have: vec_valid  input  1 / vec_thread  input  6 / vec_pc  input  16; setVec request.
REQ-008 SHALL have: chan_valid  input  1 / chan_first  input  6 / chan_last  input  6 / chan_op  input  2; updateChannel request (0 unfreeze, 1 freeze, 2 delete, 3 no-op).
REQ-009 SHALL have: frame_done  output  1  one-cycle pulse at end of pass; busy  output  1  high when not IDLE.

Function
REQ-010 SHALL hold per thread (64): pc[15:0], pend_pc[15:0], paused, pend_paused; pc=16'hFFFF means inactive; pend_pc=16'hFFFF means no change; pend_pc=16'hFFFE means kill.
REQ-011 SHALL implement FSM IDLE -> APPLY -> SCAN -> DISPATCH -> RUN -> SCAN ... -> DONE -> IDLE.
REQ-012 IDLE: on frame_start, go to APPLY with index=0; frame_start in any other state SHALL be ignored.
REQ-013 APPLY: one slot per cycle, index 0..63: paused<=pend_paused; if pend_pc==FFFE then pc<=FFFF; else if pend_pc!=FFFF then pc<=pend_pc; pend_pc<=FFFF; after slot 63 go to SCAN with index=0.
REQ-014 SCAN: one slot per cycle; slot runnable iff pc!=FFFF and paused==0; runnable -> DISPATCH; else index+1; after slot 63 not runnable -> DONE.
REQ-015 DISPATCH: run_valid=1, run_thread=index, run_pc=pc[index], held stable until run_ready=1; on handshake go to RUN.
REQ-016 RUN: on yield_valid, pc[index]<=FFFF if yield_kill else yield_pc; then index 63 -> DONE, else index+1 and SCAN.
REQ-017 yield_valid outside RUN SHALL be ignored; run_valid SHALL be 0 outside DISPATCH.
REQ-018 DONE: frame_done=1 for exactly one cycle, return to IDLE.
REQ-019 vec_valid (any state): pend_pc[vec_thread]<=vec_pc.
REQ-020 chan_valid (any state): for every t with chan_first<=t<=chan_last: op0 pend_paused<=0, op1 pend_paused<=1, op2 pend_pc<=FFFE; chan_first>chan_last SHALL change nothing.
REQ-021 vec and chan in the same cycle on the same thread: chan result SHALL win for pend_pc.
REQ-022 request to the slot being applied in APPLY this cycle: request value SHALL be the new pend_* (copy to pc/paused uses old value).
REQ-023 Latency: frame_start to frame_done with no runnable thread = 130 cycles (1 + 64 APPLY + 64 SCAN + DONE); each runnable thread adds DISPATCH and RUN cycles.

Reset
REQ-024 reset=0 at a clock edge SHALL force: state IDLE, index 0, pc[0]=0000, pc[1..63]=FFFF, all pend_pc=FFFF, all paused/pend_paused=0.
REQ-025 During/after reset: run_valid=0, frame_done=0, busy=0; reset mid-frame aborts the pass with no further pulses.

Verification
REQ-026 Post-reset frame_start, CPU ready, thread 0 yields pc=0x0123 -> run_thread=0 run_pc=0000, then frame_done 64+ cycles later; next frame run_pc=0123.
REQ-027 vec_valid thread 5 pc=0x0400 in RUN of thread 0 -> next frame offers thread 0 then thread 5 at 0400, in that order.
REQ-028 chan op1 first=0 last=0 -> next frame no offer, frame_done at 130 cycles; op0 -> following frame offers thread 0 again.
REQ-029 chan op2 first=3 last=7 with threads 3..7 active -> after next APPLY none offered; chan first=9 last=2 -> no state change.
REQ-030 Hold run_ready=0 for 20 cycles -> run_valid, run_thread, run_pc stable throughout; yield_kill=1 -> thread never offered again.
REQ-031 reset pulsed during RUN -> busy=0 next cycle, state equals REQ-024 values, next frame offers thread 0 at 0000.
